// File: rtl/char_buf_ctrl.sv
// char_buf_ctrl: text-mode character buffer between the CPU bus bridge and the
// VGA glyph/colour stage. Cells are {fg[11:0], bg[11:0], char[7:0]}.
// A hardware engine clears the whole screen, or scrolls up one row by bumping a
// physical row offset and blanking the row that becomes the new bottom line.
// Optional feature macro: CHAR_BUF_CURSOR_EN adds a blinking block cursor
// (fg/bg swap) on the display read path.
module char_buf_ctrl #(
  parameter int              ROW_W     = 5,
  parameter int              COL_W     = 7,
  parameter int              DATA_W    = 32,
  parameter logic [DATA_W-1:0] BLANK   = 32'hFFF00020,
  parameter int              BLINK_CYC = 25_000_000
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [ROW_W+COL_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0]      cpu_wdata,
  input  logic                   cpu_we,
  input  logic                   cpu_re,
  output logic [DATA_W-1:0]      cpu_rdata,
  output logic                   cpu_rvalid,
  output logic                   cpu_ready,
  input  logic [ROW_W+COL_W-1:0] vga_addr,
  output logic [DATA_W-1:0]      vga_rdata,
  input  logic                   clr_req,
  input  logic                   scroll_req,
  output logic                   busy,
  output logic [ROW_W-1:0]       row_off
`ifdef CHAR_BUF_CURSOR_EN
  ,
  input  logic [ROW_W-1:0]       cur_row,
  input  logic [COL_W-1:0]       cur_col
`endif
);

  localparam int AW    = ROW_W + COL_W;
  localparam int CELLS = 2 ** AW;

  typedef enum logic [1:0] {IDLE, CLR_ALL, CLR_ROW} state_t;

  state_t            state, state_nx;
  logic [AW-1:0]     cnt;
  logic [ROW_W-1:0]  clr_row;
  logic [DATA_W-1:0] mem [CELLS];
  logic [DATA_W-1:0] vga_raw;

  logic [ROW_W-1:0]  cpu_prow, vga_prow;
  logic [AW-1:0]     cpu_phys, vga_phys;
  logic              ram_we;
  logic [AW-1:0]     ram_waddr;
  logic [DATA_W-1:0] ram_wdata;

  // Logical rows are rotated by the scroll offset; columns map straight through.
  assign cpu_prow = cpu_addr[AW-1:COL_W] + row_off;
  assign vga_prow = vga_addr[AW-1:COL_W] + row_off;
  assign cpu_phys = {cpu_prow, cpu_addr[COL_W-1:0]};
  assign vga_phys = {vga_prow, vga_addr[COL_W-1:0]};

  assign busy      = (state != IDLE);
  assign cpu_ready = ~busy;

  // Next-state logic: clear beats scroll, engine returns to IDLE after its last cell.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (clr_req)         state_nx = CLR_ALL;
        else if (scroll_req) state_nx = CLR_ROW;
      end
      CLR_ALL: if (cnt == '1)              state_nx = IDLE;
      CLR_ROW: if (cnt[COL_W-1:0] == '1)   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register; reset aborts any engine run immediately.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nx;
  end

  // Engine cell counter and row offset; the row to blank is the pre-scroll offset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt     <= '0;
      row_off <= '0;
      clr_row <= '0;
    end else if (state == IDLE) begin
      cnt <= '0;
      if (clr_req) begin
        row_off <= '0;
      end else if (scroll_req) begin
        clr_row <= row_off;
        row_off <= row_off + ROW_W'(1);
      end
    end else begin
      cnt <= cnt + AW'(1);
    end
  end

  // Single write port: the engine owns it while busy, otherwise the CPU.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = cpu_phys;
    ram_wdata = cpu_wdata;
    case (state)
      CLR_ALL: begin
        ram_we    = 1'b1;
        ram_waddr = cnt;
        ram_wdata = BLANK;
      end
      CLR_ROW: begin
        ram_we    = 1'b1;
        ram_waddr = {clr_row, cnt[COL_W-1:0]};
        ram_wdata = BLANK;
      end
      default: ram_we = cpu_we;
    endcase
  end

  // Cell storage write; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
  end

  // Two synchronous read ports; a same-edge write is not forwarded (old data).
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cpu_rdata  <= '0;
      cpu_rvalid <= 1'b0;
      vga_raw    <= '0;
    end else begin
      cpu_rvalid <= cpu_re;
      if (cpu_re) cpu_rdata <= mem[cpu_phys];
      vga_raw <= mem[vga_phys];
    end
  end

`ifdef CHAR_BUF_CURSOR_EN
  localparam int BW = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYC - 1);

  logic [BW-1:0] blink_cnt;
  logic          phase;
  logic [AW-1:0] vga_addr_q;

  // Blink timer toggles cursor phase every BLINK_CYC cycles; display address is
  // registered so the cursor compare lines up with the 1-cycle read latency.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      blink_cnt  <= '0;
      phase      <= 1'b0;
      vga_addr_q <= '0;
    end else begin
      vga_addr_q <= vga_addr;
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt <= '0;
        phase     <= ~phase;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
    end
  end

  assign vga_rdata = (phase && (vga_addr_q == {cur_row, cur_col}))
                   ? {vga_raw[DATA_W-13 -: 12], vga_raw[DATA_W-1 -: 12], vga_raw[DATA_W-25:0]}
                   : vga_raw;
`else
  assign vga_rdata = vga_raw;
`endif

endmodule

// File: tb/tb_char_buf_ctrl.sv
// tb_char_buf_ctrl: directed bench for char_buf_ctrl (default build).
module tb_char_buf_ctrl;

  localparam logic [31:0] BLANK = 32'hFFF00020;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic [11:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic        cpu_we = 1'b0;
  logic        cpu_re = 1'b0;
  logic [31:0] cpu_rdata;
  logic        cpu_rvalid;
  logic        cpu_ready;
  logic [11:0] vga_addr = '0;
  logic [31:0] vga_rdata;
  logic        clr_req = 1'b0;
  logic        scroll_req = 1'b0;
  logic        busy;
  logic [4:0]  row_off;
`ifdef CHAR_BUF_CURSOR_EN
  logic [4:0]  cur_row = '0;
  logic [6:0]  cur_col = '0;
`endif

  int checks = 0;
  int errors = 0;

  char_buf_ctrl dut (
    .clk(clk), .rstn(rstn),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we), .cpu_re(cpu_re),
    .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid), .cpu_ready(cpu_ready),
    .vga_addr(vga_addr), .vga_rdata(vga_rdata),
    .clr_req(clr_req), .scroll_req(scroll_req), .busy(busy), .row_off(row_off)
`ifdef CHAR_BUF_CURSOR_EN
    , .cur_row(cur_row), .cur_col(cur_col)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic        re;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [11:0] vaddr;
    logic        exp_rv;
    logic [31:0] exp_rd;
    logic [31:0] exp_vga;
  } vec_t;

  vec_t vecs[9];

  function automatic logic [11:0] la(input int r, input int c);
    return {r[4:0], c[6:0]};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input int i);
    cpu_we    = vecs[i].we;
    cpu_re    = vecs[i].re;
    cpu_addr  = vecs[i].addr;
    cpu_wdata = vecs[i].wdata;
    vga_addr  = vecs[i].vaddr;
    @(negedge clk);
    checkOutput($sformatf("vec%0d_rvalid", i), 32'(cpu_rvalid), 32'(vecs[i].exp_rv));
    if (vecs[i].exp_rv) checkOutput($sformatf("vec%0d_rdata", i), cpu_rdata, vecs[i].exp_rd);
    checkOutput($sformatf("vec%0d_vga", i), vga_rdata, vecs[i].exp_vga);
  endtask

  task automatic cpu_read(input logic [11:0] a, output logic [31:0] d, output logic v);
    cpu_re   = 1'b1;
    cpu_addr = a;
    @(negedge clk);
    d      = cpu_rdata;
    v      = cpu_rvalid;
    cpu_re = 1'b0;
  endtask

  task automatic read_check(input string name, input int r, input int c, input logic [31:0] exp);
    logic [31:0] d;
    logic v;
    cpu_read(la(r, c), d, v);
    checkOutput(name, d, exp);
  endtask

  task automatic cpu_write(input logic [11:0] a, input logic [31:0] d);
    cpu_we    = 1'b1;
    cpu_addr  = a;
    cpu_wdata = d;
    @(negedge clk);
    cpu_we = 1'b0;
  endtask

  task automatic run_engine(input logic do_clr, input logic do_scr, output int n, output int ready_err);
    clr_req    = do_clr;
    scroll_req = do_scr;
    @(negedge clk);
    clr_req    = 1'b0;
    scroll_req = 1'b0;
    n = 0;
    ready_err = 0;
    while (busy && n < 5000) begin
      if (cpu_ready) ready_err++;
      n++;
      @(negedge clk);
    end
  endtask

  // Global time bound so the run always ends.
  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n, rerr, bad_d, bad_v, off0;
    logic [31:0] d;
    logic v;

    vecs[0] = '{1'b1, 1'b0, la(0, 1),   32'h0F0FF068, la(0, 1),   1'b0, 32'h0,        BLANK};
    vecs[1] = '{1'b0, 1'b1, la(0, 1),   32'h0,        la(0, 1),   1'b1, 32'h0F0FF068, 32'h0F0FF068};
    vecs[2] = '{1'b1, 1'b1, la(3, 5),   32'h12345678, la(3, 5),   1'b1, BLANK,        BLANK};
    vecs[3] = '{1'b0, 1'b1, la(3, 5),   32'h0,        la(3, 5),   1'b1, 32'h12345678, 32'h12345678};
    vecs[4] = '{1'b1, 1'b0, la(31, 127), 32'hDEADBEEF, la(31, 127), 1'b0, 32'h0,      BLANK};
    vecs[5] = '{1'b0, 1'b1, la(31, 127), 32'h0,       la(31, 127), 1'b1, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[6] = '{1'b0, 1'b1, la(0, 0),   32'h0,        la(0, 0),   1'b1, BLANK,        BLANK};
    vecs[7] = '{1'b1, 1'b0, la(0, 0),   32'hCAFEF00D, la(0, 0),   1'b0, 32'h0,        BLANK};
    vecs[8] = '{1'b0, 1'b1, la(0, 0),   32'h0,        la(0, 0),   1'b1, 32'hCAFEF00D, 32'hCAFEF00D};

    // Reset state
    #1 rstn = 1'b0;
    #12;
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_ready", 32'(cpu_ready), 32'd1);
    checkOutput("rst_rvalid", 32'(cpu_rvalid), 32'd0);
    checkOutput("rst_rdata", cpu_rdata, 32'd0);
    checkOutput("rst_vga", vga_rdata, 32'd0);
    checkOutput("rst_rowoff", 32'(row_off), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // Full clear: 4096 busy cycles, then every cell blank
    run_engine(1'b1, 1'b0, n, rerr);
    checkOutput("clr_busy_len", 32'(n), 32'd4096);
    checkOutput("clr_ready_low", 32'(rerr), 32'd0);
    checkOutput("clr_rowoff", 32'(row_off), 32'd0);
    bad_d = 0;
    bad_v = 0;
    for (int p = 0; p < 4096; p++) begin
      cpu_read(p[11:0], d, v);
      if (d !== BLANK) bad_d++;
      if (v !== 1'b1) bad_v++;
    end
    checkOutput("clr_all_blank", 32'(bad_d), 32'd0);
    checkOutput("clr_read_rvalid", 32'(bad_v), 32'd0);

    // Table-driven CPU/VGA access vectors
    for (int i = 0; i < 9; i++) applyStimulus(i);
    cpu_we = 1'b0;
    cpu_re = 1'b0;

    // Fill physical row r with 0x41+r
    for (int p = 0; p < 4096; p++) begin
      cpu_we    = 1'b1;
      cpu_addr  = p[11:0];
      cpu_wdata = 32'h41 + 32'(p >> 7);
      @(negedge clk);
    end
    cpu_we = 1'b0;

    // Scroll with a write in the request cycle and a held write during busy
    scroll_req = 1'b1;
    cpu_we     = 1'b1;
    cpu_addr   = la(1, 7);
    cpu_wdata  = 32'hABCD0001;
    @(negedge clk);
    scroll_req = 1'b0;
    cpu_addr   = la(5, 3);
    cpu_wdata  = 32'h99999999;
    n = 0;
    rerr = 0;
    while (busy && n < 5000) begin
      if (cpu_ready) rerr++;
      if (n == 10) cpu_we = 1'b0;
      n++;
      @(negedge clk);
    end
    cpu_we = 1'b0;
    checkOutput("scr_busy_len", 32'(n), 32'd128);
    checkOutput("scr_ready_low", 32'(rerr), 32'd0);
    checkOutput("scr_rowoff1", 32'(row_off), 32'd1);
    read_check("scr_r0c0", 0, 0, 32'h42);
    read_check("scr_r0c127", 0, 127, 32'h42);
    read_check("scr_r31c0", 31, 0, BLANK);
    read_check("scr_r31c127", 31, 127, BLANK);
    read_check("scr_r30c5", 30, 5, 32'h60);
    read_check("scr_reqcycle_wr", 0, 7, 32'hABCD0001);
    read_check("scr_reqcycle_other", 1, 7, 32'h43);
    read_check("scr_dropped_wr", 5, 3, 32'h47);

    // Scroll until the offset wraps
    run_engine(1'b0, 1'b1, n, rerr);
    checkOutput("scr2_busy_len", 32'(n), 32'd128);
    checkOutput("scr2_rowoff", 32'(row_off), 32'd2);
    for (int k = 0; k < 30; k++) run_engine(1'b0, 1'b1, n, rerr);
    checkOutput("scr_wrap_rowoff", 32'(row_off), 32'd0);
    run_engine(1'b0, 1'b1, n, rerr);
    checkOutput("scr33_rowoff", 32'(row_off), 32'd1);

    // Clear and scroll together: clear wins; requests during busy ignored
    clr_req    = 1'b1;
    scroll_req = 1'b1;
    @(negedge clk);
    clr_req    = 1'b0;
    scroll_req = 1'b0;
    off0 = int'(row_off);
    n = 0;
    while (busy && n < 5000) begin
      if (n == 50) scroll_req = 1'b1;
      if (n == 51) scroll_req = 1'b0;
      if (n == 60) clr_req = 1'b1;
      if (n == 61) clr_req = 1'b0;
      n++;
      @(negedge clk);
    end
    scroll_req = 1'b0;
    clr_req    = 1'b0;
    checkOutput("both_busy_len", 32'(n), 32'd4096);
    checkOutput("both_rowoff_edge", 32'(off0), 32'd0);
    repeat (3) @(negedge clk);
    checkOutput("both_no_requeue", 32'(busy), 32'd0);
    checkOutput("both_rowoff", 32'(row_off), 32'd0);

    // Reset in the middle of a clear
    cpu_write(la(0, 5), 32'h55555555);
    cpu_write(la(20, 0), 32'h00000077);
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    checkOutput("rstmid_reached", 32'(n), 32'd100);
    rstn = 1'b0;
    #1;
    checkOutput("rstmid_busy", 32'(busy), 32'd0);
    checkOutput("rstmid_ready", 32'(cpu_ready), 32'd1);
    checkOutput("rstmid_rowoff", 32'(row_off), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("rstmid_stay_idle", 32'(busy), 32'd0);
    read_check("rstmid_cleared_cell", 0, 5, BLANK);
    read_check("rstmid_untouched_cell", 20, 0, 32'h00000077);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
